// File: rtl/bd_pin_loopback.sv
// Loopback stand-in for the Braindrop pins: pin2core words are buffered in a
// show-ahead FIFO and returned on core2pin as {output-order tag, payload}.
module bd_pin_loopback #(
  parameter int NUM_BITS_IN  = 21,
  parameter int NUM_BITS_OUT = 34,
  parameter int DEPTH        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [NUM_BITS_IN-1:0]    in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [NUM_BITS_OUT-1:0]   out_data,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic [15:0]               words_seen
);
  localparam int TAG_BITS = NUM_BITS_OUT - NUM_BITS_IN;
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;

  logic [NUM_BITS_IN-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [TAG_BITS-1:0]    r_tag;
  logic                   r_in_ready;
  logic [15:0]            r_words_seen;

  logic                   w_push, w_pop, w_out_valid;
  logic [CW-1:0]          w_count_next;
  logic                   w_in_ready_next;

  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  always_comb begin
    w_count_next    = r_count + CW'(w_push) - CW'(w_pop);
    // Ready looks at post-update occupancy so a pop from full re-opens input next cycle.
    w_in_ready_next = en & (w_count_next < CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_tag        <= '0;
      r_in_ready   <= 1'b0;
      r_words_seen <= '0;
    end else begin
      r_count    <= w_count_next;
      r_in_ready <= w_in_ready_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_words_seen != 16'hFFFF) r_words_seen <= r_words_seen + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_tag    <= r_tag + TAG_BITS'(1);
      end
    end
  end

  // Storage carries no reset; contents are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = w_out_valid;
  assign out_data   = {r_tag, r_mem[r_rd_ptr]};
  assign count      = r_count;
  assign words_seen = r_words_seen;
endmodule

// File: doc/bd_pin_loopback.md
# bd_pin_loopback

Synthesizable stand-in for the Braindrop pin interface, used for board bring-up and bench closure of the FPGA↔BD link without silicon. It accepts pin2core words from the FPGA on a synchronous valid/ready port and buffers them in a FIFO. It returns each word on the core2pin port as {sequence tag, payload}. It sits where the BD pins would be, between the FPGA-side pin adapters.

## Interface
- NUM_BITS_IN, 21, pin2core word width.
- NUM_BITS_OUT, 34, core2pin word width; must exceed NUM_BITS_IN. The tag width is TAG_BITS = NUM_BITS_OUT − NUM_BITS_IN (13 by default).
- DEPTH, 16, FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  global clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high global reset.
- en  input  1  loopback enable; 0 blocks new input, while already-buffered words still drain.
- in_valid  input  1  FPGA has a pin2core word on in_data.
- in_data  input  NUM_BITS_IN  pin2core payload.
- in_ready  output  1  registered; model accepts a word this cycle.
- out_valid  output  1  core2pin word available.
- out_data  output  NUM_BITS_OUT  {tag, payload}, tag in MSBs.
- out_ready  input  1  FPGA accepts the core2pin word this cycle.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- words_seen  output  16  accepted-word counter, saturating.

## Operation
- **Push:** occurs at a rising edge where in_valid & in_ready. in_data is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- **Pop:** occurs at a rising edge where out_valid & out_ready. rd_ptr advances modulo DEPTH, and tag increments.
- **FIFO is show-ahead:** out_data = {tag, mem[rd_ptr]}, out_valid = (count != 0); both are combinational from registers.
- **Tag:** TAG_BITS counter starting at 0. It increments by 1 per pop and wraps from 2^TAG_BITS−1 to 0. The tag reflects output order, not input time.
- **Count:** count_next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- **in_ready register:** in_ready_next = en & (count_next < DEPTH). in_ready is computed from the post-update occupancy, so a full FIFO that pops in a cycle raises in_ready on the following cycle.
- **Full FIFO:** with count == DEPTH, in_ready is already 0. Input is never written while full, and data is never overwritten or dropped.
- **Empty FIFO with a push:** the word is not visible at the output in the same cycle; no bypass path.
- **Pointers:** wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally.
- **words_seen:** increments on each push and saturates at 0xFFFF.
- **en deassert:** when en goes to 0, in_ready falls at the next edge. A push is still honoured at the edge where en falls if in_ready was 1 there. Output draining is unaffected.
- **Reset:** asserting reset at any time, including mid-transfer, immediately clears wr_ptr, rd_ptr, count, tag, words_seen and in_ready to 0. Memory contents are don't-care.
- **Outputs while in reset:** in_ready = 0, out_valid = 0, count = 0, words_seen = 0. out_data is don't-care while out_valid = 0.

## Timing
- **First acceptance:** in_ready rises at the first rising edge after reset deasserts, provided en = 1.
- **Input-to-output latency:** a word pushed at edge N appears on out_valid/out_data after edge N (visible during cycle N+1). With out_ready held high, it pops at edge N+1.
- **Throughput:** one push and one pop per cycle sustained, with out_ready held high and the FIFO never full.
- **Output stability:** out_data and out_valid stay stable while out_valid & ~out_ready.
- **Back-pressure:** with out_ready = 0 and in_valid held high, exactly DEPTH words are accepted and in_ready then reads 0.

## Test plan
- **Reset state:** assert reset mid-stream with 5 words buffered → count = 0, out_valid = 0, in_ready = 0 while reset is high. After release, in_ready = 1 one edge later and tag restarts at 0.
- **Single word:** push 0x1ABCD with out_ready = 1 → out_data = 34'h0_0001ABCD one cycle later, popped next edge. A second word 0x00005 then emerges with tag 1.
- **Fill:** out_ready = 0, in_valid held, DEPTH = 16 → exactly 16 pushes, count = 16, in_ready = 0. Raising out_ready for one cycle → count = 15, and in_ready = 1 the following cycle.
- **Streaming:** push 100 sequential payloads with random out_ready (50%) and random in_valid → outputs are in order, tags 0..99, no loss or duplication, words_seen = 100.
- **Tag wrap:** stream 8193 words → tag goes 8191 then 0 on the 8193rd word. words_seen saturates after 65535 pushes in a longer run.
- **en gating:** drop en with 3 words buffered → in_ready = 0 at the next edge, all 3 words drain, and no new words are accepted until en returns.
